// File: rtl/detect_sched_if.sv
// Bundle between the lane requesters/shared detector and the detect_sched arbiter.
// The master side drives requests, lane data and the detector result; the slave side is the scheduler.
interface detect_sched_if #(
    parameter int CNT_W = 8
);
    logic [3:0]         req;
    logic [3:0]         bit_in;
    logic               det_out;
    logic [3:0]         grant;
    logic               det_q;
    logic               det_rst;
    logic               busy;
    logic               match_valid;
    logic [1:0]         match_lane;
    logic [4*CNT_W-1:0] match_cnt;

    modport master (
        output req, bit_in, det_out,
        input  grant, det_q, det_rst, busy, match_valid, match_lane, match_cnt
    );

    modport slave (
        input  req, bit_in, det_out,
        output grant, det_q, det_rst, busy, match_valid, match_lane, match_cnt
    );
endinterface

// File: rtl/detect_sched.sv
// Time-shares one serial sequence detector across 4 lanes: round-robin grant, flush, stream a frame, drain.
// Frame period FRAME_LEN+3 cycles; detector results are sampled one cycle late and counted per lane.
module detect_sched #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    detect_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DRAIN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       bit_cnt;
    logic [1:0]       lane;
    logic [1:0]       last_lane;
    logic [1:0]       pick;
    logic             found;
    logic             hit;
    logic [3:0]       grant;
    logic             det_rst;
    logic             busy;
    logic             match_valid;
    logic [1:0]       match_lane;
    logic [CNT_W-1:0] cnt [4];

    // Round-robin search begins just after the lane served last.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        pick  = last_lane + 2'd1;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = last_lane + 2'(i + 1);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.req) state_nxt = FLUSH;
            FLUSH:   state_nxt = STREAM;
            STREAM:  if (bit_cnt == CNT_LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Detector output lags its input by one cycle, so the first STREAM cycle and the
    // flush are skipped and the drain cycle picks up the last streamed bit.
    assign hit = bus.det_out && (((state == STREAM) && (bit_cnt != 8'd0)) || (state == DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            det_rst     <= 1'b1;
            busy        <= 1'b0;
            match_valid <= 1'b0;
            match_lane  <= 2'd0;
            bit_cnt     <= 8'd0;
            lane        <= 2'd0;
            last_lane   <= 2'd3;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            det_rst     <= (state_nxt == FLUSH);
            match_valid <= hit;
            if (hit) begin
                match_lane <= lane;
                if (cnt[lane] != {CNT_W{1'b1}}) cnt[lane] <= cnt[lane] + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        lane  <= pick;
                        grant <= 4'b0001 << pick;
                    end
                end
                FLUSH:  bit_cnt <= 8'd0;
                STREAM: bit_cnt <= bit_cnt + 8'd1;
                DRAIN: begin
                    grant     <= 4'b0000;
                    last_lane <= lane;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant       = grant;
    assign bus.det_q       = (state == STREAM) ? bus.bit_in[lane] : 1'b0;
    assign bus.det_rst     = det_rst;
    assign bus.busy        = busy;
    assign bus.match_valid = match_valid;
    assign bus.match_lane  = match_lane;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign bus.match_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched: arbitration order, frame timing, match counting, saturation and reset abort.
module tb_detect_sched;
    logic clk;
    logic reset;
    int   checks;
    int   fails;
    int   pulses;

    detect_sched_if #(.CNT_W(8)) bus ();

    detect_sched #(.FRAME_LEN(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_grant [5];
        checks = 0;
        fails  = 0;
        exp_grant[0] = 4'b0001;
        exp_grant[1] = 4'b0010;
        exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000;
        exp_grant[4] = 4'b0001;

        reset       = 1'b1;
        bus.req     = 4'b0000;
        bus.bit_in  = 4'b0000;
        bus.det_out = 1'b0;
        tick(2);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_det_rst", 32'(bus.det_rst), 32'h1);
        check("rst_det_q", 32'(bus.det_q), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_match_valid", 32'(bus.match_valid), 32'h0);
        check("rst_match_lane", 32'(bus.match_lane), 32'h0);
        check("rst_match_cnt", bus.match_cnt, 32'h0);

        reset = 1'b0;
        tick(1);
        check("det_rst_fall", 32'(bus.det_rst), 32'h0);
        check("idle_busy", 32'(bus.busy), 32'h0);
        check("idle_grant", 32'(bus.grant), 32'h0);

        // All lanes requesting: rotating grants, 11-cycle frames.
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check($sformatf("rr_grant%0d", k), 32'(bus.grant), 32'(exp_grant[k]));
            check($sformatf("rr_busy%0d", k), 32'(bus.busy), 32'h1);
            if (k == 4) bus.req = 4'b0000;
            tick(10);
            check($sformatf("rr_end_grant%0d", k), 32'(bus.grant), 32'h0);
            check($sformatf("rr_end_busy%0d", k), 32'(bus.busy), 32'h0);
        end

        // Lane 2 alone, single match at STREAM counter 3.
        bus.req = 4'b0100;
        tick(1);
        check("l2_grant", 32'(bus.grant), 32'h4);
        check("flush_det_rst", 32'(bus.det_rst), 32'h1);
        check("flush_det_q", 32'(bus.det_q), 32'h0);
        bus.req    = 4'b0000;
        bus.bit_in = 4'b0100;
        tick(1);
        check("stream_det_q1", 32'(bus.det_q), 32'h1);
        check("stream_det_rst", 32'(bus.det_rst), 32'h0);
        bus.bit_in = 4'b1011;
        tick(1);
        check("stream_det_q0", 32'(bus.det_q), 32'h0);
        tick(2);
        bus.det_out = 1'b1;
        tick(1);
        bus.det_out = 1'b0;
        check("l2_match_valid", 32'(bus.match_valid), 32'h1);
        check("l2_match_lane", 32'(bus.match_lane), 32'h2);
        check("l2_cnt_early", bus.match_cnt, 32'h0001_0000);
        tick(1);
        check("l2_pulse_end", 32'(bus.match_valid), 32'h0);
        bus.bit_in = 4'b0000;
        tick(4);
        check("l2_idle_busy", 32'(bus.busy), 32'h0);
        check("l2_cnt", bus.match_cnt, 32'h0001_0000);

        // Lane 1 with det_out high throughout, including flush and idle.
        bus.req     = 4'b0010;
        bus.det_out = 1'b1;
        pulses      = 0;
        tick(1);
        bus.req = 4'b0000;
        for (int i = 0; i < 11; i++) begin
            if (bus.match_valid && bus.match_lane == 2'd1) pulses++;
            tick(1);
        end
        if (bus.match_valid && bus.match_lane == 2'd1) pulses++;
        check("l1_pulses", 32'(pulses), 32'd8);
        check("l1_cnt", bus.match_cnt, 32'h0001_0800);
        bus.det_out = 1'b0;
        tick(1);

        // Lane 0 persistent: 32 frames of 8 matches saturate at 255.
        bus.req     = 4'b0001;
        bus.det_out = 1'b1;
        tick(11 * 32);
        check("l0_sat", bus.match_cnt, 32'h0001_08FF);
        pulses = 0;
        tick(1);
        check("l0_regrant", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.match_valid) pulses++;
        end
        check("l0_sat_pulses", 32'(pulses), 32'd8);
        check("l0_sat_hold", bus.match_cnt, 32'h0001_08FF);
        bus.det_out = 1'b0;
        tick(1);

        // Lane 3 drops req mid-frame: frame still runs to completion.
        bus.req = 4'b1000;
        tick(1);
        check("l3_grant", 32'(bus.grant), 32'h8);
        tick(3);
        bus.req = 4'b0000;
        tick(6);
        check("l3_drain_grant", 32'(bus.grant), 32'h8);
        check("l3_drain_busy", 32'(bus.busy), 32'h1);
        tick(1);
        check("l3_end_grant", 32'(bus.grant), 32'h0);
        check("l3_end_busy", 32'(bus.busy), 32'h0);
        tick(3);
        check("l3_no_regrant", 32'(bus.grant), 32'h0);

        // Reset asserted at STREAM counter 4 on lane 1.
        bus.req = 4'b0010;
        tick(1);
        check("l1b_grant", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        tick(5);
        bus.det_out = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_grant", 32'(bus.grant), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_cnt", bus.match_cnt, 32'h0);
        check("arst_det_rst", 32'(bus.det_rst), 32'h1);
        tick(2);
        check("arst_match_valid", 32'(bus.match_valid), 32'h0);
        reset       = 1'b0;
        bus.det_out = 1'b0;
        bus.req     = 4'b0100;
        tick(1);
        check("post_rst_grant", 32'(bus.grant), 32'h4);
        check("post_rst_cnt", bus.match_cnt, 32'h0);
        bus.req = 4'b0000;
        tick(12);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
